// File: rtl/vc_arb_resp_router_pkg.sv
// Shared definitions for the vc arbiter family: grant encoding helpers and
// the protocol-error cause codes.
package vc_arb_resp_router_pkg;

    localparam int unsigned c_max_reqs = 32;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_NOT_ONEHOT = 2'd1,
        ERR_ENQ_FULL   = 2'd2,
        ERR_RESP_EMPTY = 2'd3
    } err_cause_e;

    function automatic int unsigned onehot_to_idx(input logic [c_max_reqs-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < c_max_reqs; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [c_max_reqs-1:0] vec);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < c_max_reqs; i++) begin
            if (vec[i]) ones = ones + 1;
        end
        return (ones == 1);
    endfunction

endpackage

// File: rtl/vc_arb_resp_router_tag_queue.sv
// Circular pointer/count FIFO with val/rdy on both sides; reusable by any
// in-order tracker. Only control state is reset; entry storage is not.
module vc_arb_tag_queue
    import vc_arb_resp_router_pkg::*;
#(
    parameter int unsigned p_depth      = 4,
    parameter int unsigned p_data_nbits = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_sd,
    input  logic                    i_enq_val,
    output logic                    o_enq_rdy,
    input  logic [p_data_nbits-1:0] i_enq_data,
    output logic                    o_deq_val,
    input  logic                    i_deq_rdy,
    output logic [p_data_nbits-1:0] o_deq_data,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int unsigned PTR_W = $clog2(p_depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [p_data_nbits-1:0] r_mem [p_depth];
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;

    logic w_enq_fire;
    logic w_deq_fire;
    logic w_unused_sd;

    // The domain label only tags the stored state; it never alters behaviour.
    assign w_unused_sd = i_sd;

    assign o_full     = (r_count == CNT_W'(p_depth));
    assign o_empty    = (r_count == '0);
    assign o_enq_rdy  = !o_full;
    assign o_deq_val  = !o_empty;
    assign o_deq_data = r_mem[r_head];

    assign w_enq_fire = i_enq_val && o_enq_rdy;
    assign w_deq_fire = o_deq_val && i_deq_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + PTR_W'(1);
            if (w_deq_fire) r_head <= r_head + PTR_W'(1);
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_fire) r_mem[r_tail] <= i_enq_data;
    end

endmodule

// File: rtl/vc_arb_resp_router.sv
// Records the winning requester of each accepted grant and steers in-order
// responses from the shared resource back to that requester.
module vc_arb_resp_router
    import vc_arb_resp_router_pkg::*;
#(
    parameter int unsigned p_num_reqs  = 2,
    parameter int unsigned p_max_out   = 4,
    parameter int unsigned p_msg_nbits = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sd,
    input  logic                   grant_val,
    input  logic [p_num_reqs-1:0]  grants,
    output logic                   grant_rdy,
    input  logic                   resp_val,
    output logic                   resp_rdy,
    input  logic [p_msg_nbits-1:0] resp_msg,
    output logic [p_num_reqs-1:0]  out_val,
    input  logic [p_num_reqs-1:0]  out_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic                   err
);

    localparam int unsigned IDX_W = $clog2(p_num_reqs);

    logic [c_max_reqs-1:0] w_grants_ext;
    logic                  w_grant_onehot;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_enq_rdy;
    logic                  w_deq_val;
    logic                  w_deq_rdy;
    logic [IDX_W-1:0]      w_head_idx;
    logic                  w_full;
    logic                  w_empty;
    err_cause_e            w_err_cause;
    logic                  r_err;

    always_comb begin
        w_grants_ext = '0;
        w_grants_ext[p_num_reqs-1:0] = grants;
    end

    assign w_grant_onehot = is_onehot(w_grants_ext);
    assign w_grant_idx    = IDX_W'(onehot_to_idx(w_grants_ext));

    // A malformed grant vector is never enqueued.
    vc_arb_tag_queue #(
        .p_depth      (p_max_out),
        .p_data_nbits (IDX_W)
    ) u_tag_queue (
        .clk        (clk),
        .reset      (reset),
        .i_sd       (sd),
        .i_enq_val  (grant_val && w_grant_onehot),
        .o_enq_rdy  (w_enq_rdy),
        .i_enq_data (w_grant_idx),
        .o_deq_val  (w_deq_val),
        .i_deq_rdy  (w_deq_rdy),
        .o_deq_data (w_head_idx),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign grant_rdy = w_enq_rdy;
    assign w_deq_rdy = resp_val && out_rdy[w_head_idx];
    assign resp_rdy  = w_deq_val && out_rdy[w_head_idx];
    assign out_msg   = resp_msg;

    always_comb begin
        out_val = '0;
        if (resp_val && w_deq_val) out_val[w_head_idx] = 1'b1;
    end

    always_comb begin
        w_err_cause = ERR_NONE;
        if (grant_val && !w_grant_onehot)  w_err_cause = ERR_NOT_ONEHOT;
        else if (grant_val && w_full)      w_err_cause = ERR_ENQ_FULL;
        else if (resp_val && w_empty)      w_err_cause = ERR_RESP_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else if (w_err_cause != ERR_NONE) r_err <= 1'b1;
    end

    assign err = r_err;

endmodule

// File: tb/tb_vc_arb_resp_router.sv
// Randomised and directed bench for vc_arb_resp_router against a queue-based
// model of grant order, routing and sticky error state.
module tb_vc_arb_resp_router;

    localparam int N   = 2;
    localparam int MAX = 4;
    localparam int W   = 32;

    logic         clk;
    logic         reset;
    logic         sd;
    logic         grant_val;
    logic [N-1:0] grants;
    logic         grant_rdy;
    logic         resp_val;
    logic         resp_rdy;
    logic [W-1:0] resp_msg;
    logic [N-1:0] out_val;
    logic [N-1:0] out_rdy;
    logic [W-1:0] out_msg;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    int m_q[$];
    bit m_err = 0;

    logic [N-1:0] obs_val;
    logic         obs_resp_rdy;

    vc_arb_resp_router #(
        .p_num_reqs  (N),
        .p_max_out   (MAX),
        .p_msg_nbits (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sd        (sd),
        .grant_val (grant_val),
        .grants    (grants),
        .grant_rdy (grant_rdy),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_msg  (resp_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: applies inputs, checks all outputs at
    // the falling edge, advances the model, and returns just after the next edge.
    task automatic drive_cycle(input logic rst, input logic gv, input logic [N-1:0] g,
                               input logic rv, input logic [W-1:0] msg, input logic [N-1:0] ordy);
        logic [N-1:0] exp_val;
        bit           exp_rrdy;
        bit           full;
        bit           empty;
        bit           onehot;
        reset     = rst;
        grant_val = gv;
        grants    = g;
        resp_val  = rv;
        resp_msg  = msg;
        out_rdy   = ordy;
        sd        = $urandom_range(0, 1);
        @(negedge clk);
        full     = (m_q.size() == MAX);
        empty    = (m_q.size() == 0);
        onehot   = ($countones(g) == 1);
        exp_val  = '0;
        exp_rrdy = 1'b0;
        if (!empty) begin
            exp_rrdy = ordy[m_q[0]];
            if (rv) exp_val[m_q[0]] = 1'b1;
        end
        check("grant_rdy", grant_rdy, !full);
        check("resp_rdy", resp_rdy, exp_rrdy);
        check("out_val", out_val, exp_val);
        check("out_msg", out_msg, msg);
        check("err", err, m_err);
        obs_val      = out_val;
        obs_resp_rdy = resp_rdy;
        if (rst) begin
            m_q.delete();
            m_err = 0;
        end else begin
            if ((gv && !onehot) || (gv && full) || (rv && empty)) m_err = 1;
            if (rv && exp_rrdy) void'(m_q.pop_front());
            if (gv && onehot && !full) m_q.push_back($clog2(g));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive_cycle(0, 0, '0, 0, '0, '0);
    endtask

    task automatic do_reset();
        drive_cycle(1, 0, '0, 0, '0, '0);
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] ordy;
        int           idx;

        reset = 1'b1; sd = 1'b0; grant_val = 1'b0; grants = '0;
        resp_val = 1'b0; resp_msg = '0; out_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset
        idle();
        check("idle_grant_rdy", grant_rdy, 1);
        check("idle_resp_rdy", resp_rdy, 0);
        check("idle_out_val", out_val, 0);
        check("idle_err", err, 0);

        // In-order routing of three grants
        drive_cycle(0, 1, 2'b01, 0, '0, '0);
        drive_cycle(0, 1, 2'b10, 0, '0, '0);
        drive_cycle(0, 1, 2'b01, 0, '0, '0);
        drive_cycle(0, 0, '0, 1, 32'hA, 2'b11);
        check("route_A", obs_val, 2'b01);
        drive_cycle(0, 0, '0, 1, 32'hB, 2'b11);
        check("route_B", obs_val, 2'b10);
        drive_cycle(0, 0, '0, 1, 32'hC, 2'b11);
        check("route_C", obs_val, 2'b01);
        check("drained_resp_rdy", resp_rdy, 0);

        // Full queue: simultaneous grant and response blocks the grant
        for (int i = 0; i < MAX; i++) drive_cycle(0, 1, 2'b10, 0, '0, '0);
        check("full_grant_rdy", grant_rdy, 0);
        drive_cycle(0, 1, 2'b01, 1, 32'h77, 2'b11);
        check("full_deq_route", obs_val, 2'b10);
        check("after_deq_grant_rdy", grant_rdy, 1);
        check("grant_while_full_err", err, 1);
        drive_cycle(0, 1, 2'b01, 0, '0, '0);
        check("refill_grant_rdy", grant_rdy, 0);
        do_reset();
        check("reset_err", err, 0);
        check("reset_grant_rdy", grant_rdy, 1);

        // Head requester stalls for three cycles
        drive_cycle(0, 1, 2'b01, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, '0, 1, 32'h55, 2'b10);
            check("stall_resp_rdy", obs_resp_rdy, 0);
            check("stall_out_val", obs_val, 2'b01);
        end
        drive_cycle(0, 0, '0, 1, 32'h55, 2'b01);
        check("stall_accept", obs_resp_rdy, 1);
        idle();
        check("stall_no_err", err, 0);

        // Response while empty, then malformed grants
        drive_cycle(0, 0, '0, 1, 32'h99, 2'b11);
        check("empty_resp_rdy", obs_resp_rdy, 0);
        check("empty_resp_err", err, 1);
        do_reset();
        drive_cycle(0, 1, 2'b11, 0, '0, '0);
        check("not_onehot_err", err, 1);
        drive_cycle(0, 1, 2'b00, 0, '0, '0);
        drive_cycle(0, 0, '0, 1, 32'h1, 2'b11);
        check("not_onehot_not_enq", obs_resp_rdy, 0);
        do_reset();

        // Reset discards outstanding tags
        drive_cycle(0, 1, 2'b01, 0, '0, '0);
        drive_cycle(0, 1, 2'b10, 0, '0, '0);
        do_reset();
        check("rst_out_err", err, 0);
        drive_cycle(0, 0, '0, 1, 32'h3, 2'b11);
        check("rst_out_empty", obs_resp_rdy, 0);
        do_reset();

        // Ten sequential transactions wrap the pointers
        for (int t = 0; t < 10; t++) begin
            idx = $urandom_range(0, N - 1);
            g = '0;
            g[idx] = 1'b1;
            drive_cycle(0, 1, g, 0, '0, '0);
            drive_cycle(0, 0, '0, 1, $urandom, 2'b11);
            check("wrap_route", obs_val, g);
        end
        check("wrap_err", err, 0);

        // Random traffic with periodic reset
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                do_reset();
            end else begin
                idx = $urandom_range(0, N - 1);
                g = '0;
                g[idx] = 1'b1;
                if ($urandom_range(0, 19) == 0) g = N'($urandom);
                ordy = N'($urandom);
                drive_cycle(0, ($urandom_range(0, 9) < 6), g, ($urandom_range(0, 9) < 6), $urandom, ordy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vc_arb_resp_router.md
# vc_arb_resp_router

Response-side companion to the round-robin request arbiters. It records, in grant order, which requester won each accepted request, then steers each in-order response from the shared resource back to that requester with a val/rdy handshake. It sits between the single memory/resource response port and the N requester response ports. All request/response state is labelled with the requesters' security domain `sd`.

## Interface
Parameters:
- p_num_reqs, 2: number of requesters; must be at least 2.
- p_max_out, 4: maximum outstanding requests (tag queue depth); must be a power of two and at least 2.
- p_msg_nbits, 32: response message width.

Ports (labels in brackets):
- clk  in  1  clock [L]
- reset  in  1  synchronous, active-high reset [L]
- sd  in  1  security domain of the request/response traffic [L]
- grant_val  in  1  request handshake fired this cycle for the granted requester [Domain sd]
- grants  in  p_num_reqs  one-hot grant vector from the arbiter [Domain sd]
- grant_rdy  out  1  room for another outstanding tag; upstream arbiter must gate request firing with this [Domain sd]
- resp_val  in  1  shared response valid [Domain sd]
- resp_rdy  out  1  shared response accepted [Domain sd]
- resp_msg  in  p_msg_nbits  shared response payload [Domain sd]
- out_val  out  p_num_reqs  per-requester response valid, at most one bit set [Domain sd]
- out_rdy  in  p_num_reqs  per-requester response ready [Domain sd]
- out_msg  out  p_msg_nbits  payload broadcast to all requesters [Domain sd]
- err  out  1  sticky protocol-error flag [Domain sd]

## Operation
- Tag queue: circular FIFO of p_max_out entries, each $clog2(p_num_reqs) bits wide, holding the encoded grant index. It has a count register with width $clog2(p_max_out)+1, plus a head pointer and a tail pointer that each wrap modulo p_max_out.
- Enqueue: fires when grant_val && grant_rdy. It writes the index of the set bit of grants at tail. grant_rdy = (count != p_max_out).
- Dequeue: fires when resp_val && resp_rdy. head advances by 1.
- Steering: out_val[i] = resp_val && !empty && (head_idx == i). resp_rdy = !empty && out_rdy[head_idx]. out_msg = resp_msg, passed through combinationally.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When full, enqueue is still blocked even if a dequeue fires in the same cycle. There is no full bypass.
  - When empty, there is no bypass: a response cannot be routed in the same cycle as its own grant.
- Error conditions (err is set and stays set until reset):
  - grant_val is asserted while grants is not one-hot (zero bits set or more than one). The entry is not enqueued.
  - grant_val is asserted while full.
  - resp_val is asserted while empty. The response is not accepted: resp_rdy stays 0.
- sd affects labels only; routing is identical for all domains.

## Timing
- Reset values: count=0, head=0, tail=0, err=0, grant_rdy=1, resp_rdy=0, out_val=0.
- Reset asserted mid-operation discards all outstanding tags at the next edge. Responses for requests issued before reset are then routed as errors.
- Grant-to-route latency: at least 1 cycle. A tag enqueued at edge k is routable in cycle k+1.
- Response path: zero-cycle combinational pass from resp_* to out_*, and from out_rdy to resp_rdy.
- grant_rdy depends only on registered state, so no combinational path runs from the grant inputs to grant_rdy.
- Throughput: one grant and one response per cycle, sustained.

## Structure
- Shared header (vc-arbiters definitions file): the one-hot-to-index encode function and the error-cause constants.
- One sub-module, vc_arb_tag_queue: pointer/count FIFO with enq/deq val/rdy, labelled [Domain sd] with sd [L]. It is reusable by other in-order trackers.
- The top level adds the one-hot encode, the steering muxes and the err register.

## Test plan
- Reset, then idle: grant_rdy=1, resp_rdy=0, out_val=0, err=0.
- Grants 01, 10, 01 on consecutive cycles, then three responses 0xA, 0xB, 0xC with all out_rdy=1: 0xA goes to out_val=01, 0xB to 10, 0xC to 01, then the queue is empty.
- p_max_out=4, four grants with no response: grant_rdy=0. Next cycle, grant and response fire together: the grant is blocked, count goes to 3 and grant_rdy=1.
- Head requester holds out_rdy=0 for 3 cycles while resp_val=1: resp_rdy=0 and out_val stays asserted with the same message; accepted on the cycle out_rdy rises.
- resp_val=1 while empty: resp_rdy=0 and err=1 next cycle. grants=11 with grant_val: err=1 and count unchanged.
- Reset with 2 outstanding tags: count=0 and err=0 after the edge, and wraparound of head/tail past entry 3 routes correctly across 10 sequential transactions.
